// File: rtl/wishbone_bus_if_pkg.sv
// Shared constants and types for the Wishbone bus interface.
// Holds the reset polarity, stall encodings, the zero word, the bus width
// and the FSM state encodings so no module carries local magic numbers.
package wishbone_bus_if_pkg;

    localparam int          REG_BUS_W  = 32;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic        STOP       = 1'b1;
    localparam logic        NO_STOP    = 1'b0;
    localparam logic [5:0]  NO_STALL   = {6{NO_STOP}};
    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    // FSM state encodings (also visible on the state_o debug port)
    localparam logic [1:0]  WB_IDLE           = 2'b00;
    localparam logic [1:0]  WB_BUSY           = 2'b01;
    localparam logic [1:0]  WB_WAIT_FOR_STALL = 2'b11;

    // Registered request fields presented on the Wishbone bus
    typedef struct packed {
        logic                 we;
        logic [3:0]           sel;
        logic [REG_BUS_W-1:0] addr;
        logic [REG_BUS_W-1:0] data;
    } wb_req_t;

    localparam wb_req_t WB_REQ_NONE = '{we: 1'b0, sel: 4'h0, addr: ZERO_WORD, data: ZERO_WORD};

endpackage

// File: rtl/wishbone_bus_if.sv
// Wishbone master adapter between a pipelined CPU memory port and a
// Wishbone bus. A CPU request seen in IDLE is latched onto registered bus
// outputs; the FSM waits in BUSY for ack, then either returns to IDLE or
// parks in WAIT_FOR_STALL (holding read data) until the pipeline unstalls.
// Used twice at the SoC level (instruction side and data side).
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   stall_i[5:0], flush_i - pipeline stall vector / exception flush
//   cpu_*_i               - CPU request (ce, we, addr, sel, store data)
//   cpu_data_o            - load data back to the MEM stage (combinational)
//   stallreq_o            - stall request to the pipeline controller
//   wishbone_*            - Wishbone master signals (outputs registered)
//   state_o               - current FSM state, for debug/observation
//
// Handshake: a request is accepted on the edge where state is IDLE,
// cpu_ce_i=1 and flush_i=0. The CPU must hold its request inputs stable
// while stallreq_o=1. A bus transfer completes on the edge where
// stb/cyc are high and wishbone_ack_i=1.
module wishbone_bus_if
    import wishbone_bus_if_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           stall_i,
    input  logic                 flush_i,
    input  logic                 cpu_ce_i,
    input  logic                 cpu_we_i,
    input  logic [REG_BUS_W-1:0] cpu_addr_i,
    input  logic [3:0]           cpu_sel_i,
    input  logic [REG_BUS_W-1:0] cpu_data_i,
    output logic [REG_BUS_W-1:0] cpu_data_o,
    output logic                 stallreq_o,
    input  logic                 wishbone_ack_i,
    input  logic [REG_BUS_W-1:0] wishbone_data_i,
    output logic [REG_BUS_W-1:0] wishbone_addr_o,
    output logic [REG_BUS_W-1:0] wishbone_data_o,
    output logic                 wishbone_we_o,
    output logic [3:0]           wishbone_sel_o,
    output logic                 wishbone_stb_o,
    output logic                 wishbone_cyc_o,
    output logic [1:0]           state_o
);

    logic [1:0]           state_q, state_d;
    wb_req_t              req_q, req_d;
    logic                 stb_q, stb_d;
    logic                 cyc_q, cyc_d;
    logic [REG_BUS_W-1:0] rd_buf_q, rd_buf_d;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        stb_d    = stb_q;
        cyc_d    = cyc_q;
        rd_buf_d = rd_buf_q;
        case (state_q)
            WB_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    req_d    = '{we: cpu_we_i, sel: cpu_sel_i, addr: cpu_addr_i, data: cpu_data_i};
                    stb_d    = 1'b1;
                    cyc_d    = 1'b1;
                    rd_buf_d = ZERO_WORD;
                    state_d  = WB_BUSY;
                end
            end
            WB_BUSY: begin
                // Flush wins over a simultaneous ack: the access is dropped.
                if (flush_i) begin
                    req_d    = WB_REQ_NONE;
                    stb_d    = 1'b0;
                    cyc_d    = 1'b0;
                    rd_buf_d = ZERO_WORD;
                    state_d  = WB_IDLE;
                end else if (wishbone_ack_i) begin
                    req_d = WB_REQ_NONE;
                    stb_d = 1'b0;
                    cyc_d = 1'b0;
                    if (!cpu_we_i) begin
                        rd_buf_d = wishbone_data_i;
                    end
                    // If another stage is still stalled the load data has to
                    // be replayed from the buffer once the pipeline moves.
                    state_d = (stall_i != NO_STALL) ? WB_WAIT_FOR_STALL : WB_IDLE;
                end
            end
            WB_WAIT_FOR_STALL: begin
                if (stall_i == NO_STALL || flush_i) begin
                    state_d = WB_IDLE;
                end
            end
            default: begin
                req_d    = WB_REQ_NONE;
                stb_d    = 1'b0;
                cyc_d    = 1'b0;
                rd_buf_d = ZERO_WORD;
                state_d  = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q  <= WB_IDLE;
            req_q    <= WB_REQ_NONE;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = ZERO_WORD;
        case (state_q)
            WB_IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
            end
            WB_BUSY: begin
                stallreq_o = ~wishbone_ack_i;
                if (wishbone_ack_i && !cpu_we_i) begin
                    cpu_data_o = wishbone_data_i;
                end
            end
            WB_WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_q;
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

    assign wishbone_addr_o = req_q.addr;
    assign wishbone_data_o = req_q.data;
    assign wishbone_we_o   = req_q.we;
    assign wishbone_sel_o  = req_q.sel;
    assign wishbone_stb_o  = stb_q;
    assign wishbone_cyc_o  = cyc_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
module tb_wishbone_bus_if;
    import wishbone_bus_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        wishbone_ack_i;
    logic [31:0] wishbone_data_i;
    logic [31:0] wishbone_addr_o;
    logic [31:0] wishbone_data_o;
    logic        wishbone_we_o;
    logic [3:0]  wishbone_sel_o;
    logic        wishbone_stb_o;
    logic        wishbone_cyc_o;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    wishbone_bus_if dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .cpu_ce_i        (cpu_ce_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_addr_i      (cpu_addr_i),
        .cpu_sel_i       (cpu_sel_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_data_o      (cpu_data_o),
        .stallreq_o      (stallreq_o),
        .wishbone_ack_i  (wishbone_ack_i),
        .wishbone_data_i (wishbone_data_i),
        .wishbone_addr_o (wishbone_addr_o),
        .wishbone_data_o (wishbone_data_o),
        .wishbone_we_o   (wishbone_we_o),
        .wishbone_sel_o  (wishbone_sel_o),
        .wishbone_stb_o  (wishbone_stb_o),
        .wishbone_cyc_o  (wishbone_cyc_o),
        .state_o         (state_o)
    );

    function automatic logic [70:0] bus_obs();
        return {wishbone_stb_o, wishbone_cyc_o, wishbone_we_o, wishbone_sel_o,
                wishbone_addr_o, wishbone_data_o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst             = 1'b0;
        stall_i         = 6'b0;
        flush_i         = 1'b0;
        cpu_ce_i        = 1'b0;
        cpu_we_i        = 1'b0;
        cpu_addr_i      = 32'h0;
        cpu_sel_i       = 4'h0;
        cpu_data_i      = 32'h0;
        wishbone_ack_i  = 1'b0;
        wishbone_data_i = 32'h0;
    endtask

    // One complete CPU access as seen cycle by cycle. The expected behaviour
    // is laid out as a timeline: one request cycle, wait_n+1 bus cycles
    // (ack in the last one), then, if the pipeline is still stalled at ack,
    // hold+1 parked cycles (stall asserted for the first hold of them).
    task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel,
                           input logic [31:0] rdata, input int wait_n, input int hold,
                           input logic [5:0] stall_pat);
        int          busy_n;
        int          total;
        logic        in_busy;
        logic        ack_c;
        logic        in_wait;
        logic [1:0]  st_exp;
        logic        sr_exp;
        logic [31:0] d_exp;
        logic [70:0] bus_exp;
        busy_n = wait_n + 1;
        total  = 1 + busy_n + ((hold > 0) ? hold + 1 : 0);
        for (int c = 0; c < total; c++) begin
            in_busy = (c >= 1) && (c <= busy_n);
            ack_c   = (c == busy_n);
            in_wait = (c > busy_n);
            cpu_ce_i        = 1'b1;
            cpu_we_i        = we;
            cpu_addr_i      = addr;
            cpu_sel_i       = sel;
            cpu_data_i      = wdata;
            flush_i         = 1'b0;
            wishbone_ack_i  = ack_c;
            wishbone_data_i = ack_c ? rdata : $urandom();
            if (ack_c)        stall_i = (hold > 0) ? stall_pat : 6'b0;
            else if (in_wait) stall_i = ((c - busy_n - 1) < hold) ? stall_pat : 6'b0;
            else              stall_i = 6'b0;

            if (in_busy) begin
                st_exp  = WB_BUSY;
                sr_exp  = !ack_c;
                d_exp   = (ack_c && !we) ? rdata : 32'h0;
                bus_exp = {1'b1, 1'b1, we, sel, addr, wdata};
            end else if (in_wait) begin
                st_exp  = WB_WAIT_FOR_STALL;
                sr_exp  = 1'b0;
                d_exp   = we ? 32'h0 : rdata;
                bus_exp = '0;
            end else begin
                st_exp  = WB_IDLE;
                sr_exp  = 1'b1;
                d_exp   = 32'h0;
                bus_exp = '0;
            end

            #4;
            checks++;
            if (state_o !== st_exp) begin
                failures++;
                $display("FAIL %s state c=%0d: got %0d want %0d", name, c, state_o, st_exp);
            end
            checks++;
            if (stallreq_o !== sr_exp) begin
                failures++;
                $display("FAIL %s stallreq c=%0d: got %b want %b", name, c, stallreq_o, sr_exp);
            end
            checks++;
            if (cpu_data_o !== d_exp) begin
                failures++;
                $display("FAIL %s cpu_data c=%0d: got %h want %h", name, c, cpu_data_o, d_exp);
            end
            checks++;
            if (bus_obs() !== bus_exp) begin
                failures++;
                $display("FAIL %s bus c=%0d: got %h want %h", name, c, bus_obs(), bus_exp);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        #3;
        checks++;
        if (state_o !== WB_IDLE || bus_obs() !== 71'h0) begin
            failures++;
            $display("FAIL reset_state: got st=%0d bus=%h want st=0 bus=0", state_o, bus_obs());
        end
        checks++;
        if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got sr=%b d=%h want 0/0", stallreq_o, cpu_data_o);
        end
        rst = 1'b0;
        next_cycle();
        #3;
        checks++;
        if (state_o !== WB_IDLE || stallreq_o !== 1'b0 || cpu_data_o !== 32'h0 || bus_obs() !== 71'h0) begin
            failures++;
            $display("FAIL post_reset_idle: got st=%0d sr=%b d=%h bus=%h want all 0",
                     state_o, stallreq_o, cpu_data_o, bus_obs());
        end
        next_cycle();
    endtask

    task automatic test_read();
        run_txn("read3", 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF, 2, 0, 6'b0);
        run_txn("read_min", 1'b0, 32'h0000_1040, 32'h0, 4'h1, 32'h0BAD_F00D, 0, 0, 6'b0);
    endtask

    task automatic test_write();
        run_txn("write", 1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF, 0, 0, 6'b0);
        run_txn("write_stall", 1'b1, 32'h0000_2008, 32'h8765_4321, 4'b1100, 32'hAAAA_5555, 1, 2, 6'b000100);
    endtask

    task automatic test_stall_wait();
        run_txn("stall_wait", 1'b0, 32'h0000_3000, 32'h0, 4'hF, 32'hCAFE_0001, 0, 2, 6'b001111);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_a", 1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'h1111_2222, 0, 0, 6'b0);
        run_txn("b2b_b", 1'b1, 32'h0000_4004, 32'h3333_4444, 4'hF, 32'h0, 1, 0, 6'b0);
        run_txn("b2b_c", 1'b0, 32'h0000_4008, 32'h0, 4'hF, 32'h5555_6666, 0, 1, 6'b100000);
    endtask

    task automatic test_flush_busy();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_5000; cpu_sel_i = 4'hF;
        next_cycle();
        next_cycle();
        flush_i = 1'b1; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h7777_8888;
        #3;
        checks++;
        if (state_o !== WB_BUSY || wishbone_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_busy_pre: got st=%0d cyc=%b want 1/1", state_o, wishbone_cyc_o);
        end
        next_cycle();
        drive_idle();
        stall_i = 6'b000011;
        #3;
        checks++;
        if (state_o !== WB_IDLE || bus_obs() !== 71'h0 || cpu_data_o !== 32'h0 || stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy_post: got st=%0d bus=%h d=%h sr=%b want idle/0",
                     state_o, bus_obs(), cpu_data_o, stallreq_o);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_flush_wait();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_6000; cpu_sel_i = 4'hF;
        next_cycle();
        wishbone_ack_i = 1'b1; wishbone_data_i = 32'h9999_0000; stall_i = 6'b111111;
        next_cycle();
        wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0; flush_i = 1'b1;
        #3;
        checks++;
        if (state_o !== WB_WAIT_FOR_STALL || cpu_data_o !== 32'h9999_0000) begin
            failures++;
            $display("FAIL flush_wait_pre: got st=%0d d=%h want 3/99990000", state_o, cpu_data_o);
        end
        next_cycle();
        drive_idle();
        #3;
        checks++;
        if (state_o !== WB_IDLE || cpu_data_o !== 32'h0) begin
            failures++;
            $display("FAIL flush_wait_post: got st=%0d d=%h want 0/0", state_o, cpu_data_o);
        end
        next_cycle();
    endtask

    task automatic test_reset_busy();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_7000;
        cpu_sel_i = 4'hF; cpu_data_i = 32'h0F0F_0F0F;
        next_cycle();
        rst = 1'b1;
        #3;
        checks++;
        if (wishbone_cyc_o !== 1'b1 || wishbone_addr_o !== 32'h0000_7000) begin
            failures++;
            $display("FAIL reset_busy_pre: got cyc=%b addr=%h want 1/00007000", wishbone_cyc_o, wishbone_addr_o);
        end
        next_cycle();
        drive_idle();
        #3;
        checks++;
        if (state_o !== WB_IDLE || bus_obs() !== 71'h0) begin
            failures++;
            $display("FAIL reset_busy_post: got st=%0d bus=%h want 0/0", state_o, bus_obs());
        end
        next_cycle();
    endtask

    task automatic test_flush_idle();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_8000; cpu_sel_i = 4'hF;
        flush_i = 1'b1;
        #3;
        checks++;
        if (stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_sr: got %b want 0", stallreq_o);
        end
        next_cycle();
        cpu_ce_i = 1'b0; flush_i = 1'b0;
        #3;
        checks++;
        if (state_o !== WB_IDLE || bus_obs() !== 71'h0) begin
            failures++;
            $display("FAIL flush_idle_bus: got st=%0d bus=%h want 0/0", state_o, bus_obs());
        end
        // Idle with no request: nothing moves.
        next_cycle();
        #3;
        checks++;
        if (state_o !== WB_IDLE || stallreq_o !== 1'b0 || bus_obs() !== 71'h0) begin
            failures++;
            $display("FAIL idle_hold: got st=%0d sr=%b bus=%h want idle/0", state_o, stallreq_o, bus_obs());
        end
        next_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic [5:0] pat;
            pat = 6'($urandom_range(1, 63));
            run_txn("rand", 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                    4'($urandom_range(0, 15)), $urandom(),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), pat);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        rst = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_stall_wait();
        test_back_to_back();
        test_flush_busy();
        test_flush_wait();
        test_reset_busy();
        test_flush_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wishbone_bus_if.md
WISHBONE_BUS_IF -- requirements
Module: wishbone_bus_if

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high (`RstEnable` = 1'b1).
REQ-003 SHALL have ports stall_i input 6 (pipeline stall vector, bit=1 `Stop`) and flush_i input 1 (exception pipeline flush).
REQ-004 SHALL have CPU-side inputs cpu_ce_i 1 (access request), cpu_we_i 1 (1=write), cpu_addr_i 32, cpu_sel_i 4 (byte lanes), cpu_data_i 32 (store data).
REQ-005 SHALL have CPU-side outputs cpu_data_o 32 (load data to MEM stage) and stallreq_o 1 (stall request to ctrl).
REQ-006 SHALL have bus inputs wishbone_ack_i 1 and wishbone_data_i 32.
REQ-007 SHALL have registered bus outputs wishbone_addr_o 32, wishbone_data_o 32, wishbone_we_o 1, wishbone_sel_o 4, wishbone_stb_o 1, wishbone_cyc_o 1.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, WAIT_FOR_STALL; reset state IDLE.
REQ-009 IDLE, cpu_ce_i=1 and flush_i=0: next edge SHALL latch addr/data/we/sel onto the bus, assert stb=cyc=1, go BUSY, clear read buffer.
REQ-010 IDLE, cpu_ce_i=0 or flush_i=1: SHALL stay IDLE, bus outputs unchanged-idle (stb=cyc=we=0).
REQ-011 BUSY, wishbone_ack_i=1: next edge SHALL deassert stb/cyc, zero addr/data/we/sel; if read (cpu_we_i=0) capture wishbone_data_i into read buffer.
REQ-012 BUSY ack exit: SHALL go WAIT_FOR_STALL if stall_i != 6'b000000, else IDLE.
REQ-013 BUSY, ack=0: SHALL hold all bus outputs stable and stay BUSY (no timeout).
REQ-014 BUSY, flush_i=1 (ack or not): SHALL abort — deassert stb/cyc, zero bus outputs, clear read buffer, go IDLE; flush has priority over ack.
REQ-015 WAIT_FOR_STALL: SHALL go IDLE when stall_i == 0 or flush_i=1; otherwise hold.
REQ-016 stallreq_o SHALL be combinational: IDLE -> cpu_ce_i & ~flush_i; BUSY -> ~wishbone_ack_i; WAIT_FOR_STALL -> 0.
REQ-017 cpu_data_o SHALL be combinational: BUSY with ack and read -> wishbone_data_i; WAIT_FOR_STALL -> read buffer; all other cases -> `ZeroWord`.
REQ-018 Minimum access latency SHALL be 2 cycles (request cycle + ack cycle); stallreq_o deasserts in the ack cycle.
REQ-019 A write SHALL never update the read buffer; write returns cpu_data_o = 0.
REQ-020 Back-to-back accesses SHALL start only from IDLE; new request in the cycle after ack exit to IDLE is accepted normally.

Reset
REQ-021 rst=1 at an edge SHALL force state IDLE, all bus outputs 0, read buffer 0, from any state including mid-BUSY (bus cycle abandoned, cyc dropped next edge).
REQ-022 During and after reset, with no request, stallreq_o=0 and cpu_data_o=0.

Structure
REQ-023 State encodings, `RstEnable`, `Stop`/`NoStop`, `ZeroWord`, `RegBus` SHALL live in shared define.v; no local magic constants.
REQ-024 SHALL be a single module with no sub-module; top level instantiates it twice (instruction bus, data bus) — no port specialisation per side.

Verification
REQ-025 Read, ack after 3 cycles: ce=1,we=0,addr=0x0000_1000,sel=4'hF, ack with data 0xDEAD_BEEF, stall_i=0 -> stb/cyc high 3 cycles, stallreq_o=1 until ack cycle, cpu_data_o=0xDEAD_BEEF in ack cycle, IDLE next.
REQ-026 Write: we=1,addr=0x0000_2004,data=0x1234_5678,sel=4'b0011, ack cycle 2 -> bus shows those values while BUSY, cpu_data_o=0 throughout.
REQ-027 Ack with stall_i=6'b001111 held 2 cycles after ack, read 0xCAFE_0001 -> state WAIT_FOR_STALL, stallreq_o=0, cpu_data_o=0xCAFE_0001 until stall_i=0, then IDLE.
REQ-028 Flush mid-BUSY (flush_i=1 cycle 2, ack same cycle) -> stb/cyc 0 next edge, IDLE, buffer 0, no data returned.
REQ-029 rst=1 while BUSY -> next edge all bus outputs 0, state IDLE; request with flush_i=1 in IDLE -> no bus cycle, stallreq_o=0.
